// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared word width, FSM state type and overflow helper
package wide_add_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign, result disagrees.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/wide_add_sequencer_lf.sv
// rtl/wide_add_sequencer_lf.sv - combinational 16-bit Ladner-Fischer prefix adder
module LadnerFischer
  import wide_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W-1:0] g, p, gn, pn;
  logic [WORD_W:0]   c;

  // Minimum-depth prefix tree: at level k, each bit with bit k of its index
  // set absorbs the group ending just below its 2^k-aligned block.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gn = g;
    pn = p;
    for (int k = 0; k < 4; k++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < WORD_W; i++) begin
        if (((i >> k) & 1) == 1) begin
          gn[i] = g[i] | (p[i] & g[((i >> k) << k) - 1]);
          pn[i] = p[i] & p[((i >> k) << k) - 1];
        end
      end
      g = gn;
      p = pn;
    end
    c[0] = cin;
    for (int i = 0; i < WORD_W; i++) begin
      c[i+1] = g[i] | (p[i] & cin);
    end
  end

  assign sum  = a ^ b ^ c[WORD_W-1:0];
  assign cout = c[WORD_W];

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-word add/subtract, one 16-bit slice per cycle LSW first
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter  int NUM_WORDS = 4,
  localparam int W         = WORD_W * NUM_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int           IW   = $clog2(NUM_WORDS);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  state_t            state, state_n;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [W-1:0]      a_reg, b_reg;
  logic              sub_reg;
  logic [WORD_W-1:0] core_a, core_b, core_sum;
  logic              core_cout;

  // Subtract is A + ~B + 1; the +1 enters through the initial carry.
  assign core_a = a_reg[idx*WORD_W +: WORD_W];
  assign core_b = b_reg[idx*WORD_W +: WORD_W] ^ {WORD_W{sub_reg}};

  LadnerFischer u_core (
    .a    (core_a),
    .b    (core_b),
    .cin  (carry),
    .sum  (core_sum),
    .cout (core_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = RUN;
      RUN:     if (idx == LAST) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg   <= in_a;
          b_reg   <= in_b;
          sub_reg <= in_sub;
          idx     <= '0;
          carry   <= in_sub ? 1'b1 : in_cin;
        end
        RUN: begin
          out_sum[idx*WORD_W +: WORD_W] <= core_sum;
          carry <= core_cout;
          if (idx == LAST) begin
            out_cout <= core_cout;
            out_ovf  <= signed_ovf(core_a[WORD_W-1], core_b[WORD_W-1], core_sum[WORD_W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - directed-vector self-checking bench for wide_add_sequencer
module tb_wide_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_sub, in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;

  wide_add_sequencer #(.NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    check("acc_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_sub = ~sub; in_cin = ~cin;
  endtask

  task automatic wait_result(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    logic got;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk);
      #1;
      n++;
      got = out_valid;
    end
    check({tag, "_lat"}, 64'(n), 64'd4);
    if (got) begin
      check({tag, "_sum"}, out_sum, es);
      check({tag, "_cout"}, 64'(out_cout), 64'(ec));
      check({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
      check({tag, "_busy"}, 64'(busy), 64'd1);
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    do_accept(a, b, sub, cin);
    wait_result(tag, es, ec, eo);
    release_out(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", out_sum, 64'd0);
    check("rst_cout", 64'(out_cout), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    run_op("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
    run_op("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 64'd7, 64'd5, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0);
    run_op("sub_cin_ign", 64'd7, 64'd5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0);
    run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("ovf_neg", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
           64'h2222_2222_2222_2211, 1'b0, 1'b0);

    // Backpressure with competing requests
    do_accept(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    wait_result("bp", 64'h2222_2222_2222_2211, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 3 == 0);
      in_a = 64'(i); in_b = 64'h55;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_sum", out_sum, 64'h2222_2222_2222_2211);
      check("bp_cout", 64'(out_cout), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b1; in_a = 64'h10; in_b = 64'h20; in_sub = 1'b0; in_cin = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_vld_drop", 64'(out_valid), 64'd0);
    check("bp_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_pend_acc", 64'(busy), 64'd1);
    wait_result("bp_pend", 64'h30, 1'b0, 1'b0);
    release_out("bp_pend");

    // Reset two cycles into RUN, with a request present on the reset edge
    do_accept(64'hDEAD_BEEF_0000_FFFF, 64'h1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1; in_valid = 1'b1; in_a = 64'h99; in_b = 64'h1; in_sub = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd1);
    check("mid_sum", out_sum, 64'd0);
    check("mid_busy_clr", 64'(busy), 64'd0);
    run_op("post_rst", 64'h1234, 64'h1, 1'b0, 1'b0, 64'h1235, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
